bp_update_sequencer: RTL and testbench
======================================

# bp_update_sequencer

Controller that shares the branch predictor's single `pc` port between front-end fetch lookups and queued predictor/BTB training updates. Two branch-resolution sources push resolved outcomes into a small FIFO. The sequencer grants the predictor port each cycle either to fetch (lookup) or to the FIFO head (update). Starvation of updates is bounded by a high-water mark and a wait counter.

## Interface

Parameters:
- `DEPTH`, 4 — update FIFO entries (power of two, ≥2).
- `HIGH_WATER`, 3 — occupancy at or above which updates pre-empt fetch.
- `MAX_WAIT`, 8 — consecutive denied cycles after which the head update is forced.

Ports:
- `clk`  in  1  — single clock; all state on rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `res_valid`  in  2  — per-source resolved-branch valid (source 0, source 1).
- `res_ready`  out  2  — per-source accept; transfer when valid & ready at the edge.
- `res_pc0`, `res_pc1`  in  32 — branch PC per source.
- `res_taken`  in  2  — resolved direction per source.
- `res_target0`, `res_target1`  in  32 — resolved target per source.
- `fetch_req`  in  1  — front end requests a lookup this cycle.
- `fetch_pc`  in  32 — lookup PC.
- `fetch_grant`  out  1 — predictor output is valid for `fetch_pc` this cycle; when low, fetch must stall and retry.
- `bp_pc`  out  32 — to predictor `pc`.
- `bp_update`  out  1 — to predictor `update`.
- `bp_update_taken`  out  1 — to predictor `update_taken`.
- `bp_update_target`  out  32 — to predictor `update_target`.
- `pending`  out  log2(DEPTH)+1 — current FIFO occupancy.

## Operation

- **State:** FIFO storage (pc, taken, target); head/tail pointers; `count`; `wait_cnt` (saturating at MAX_WAIT); round-robin bit `rr` (source favoured on contention).
- **Select (combinational, from registered state):**
  - `sel_upd = count!=0 && (!fetch_req || count>=HIGH_WATER || wait_cnt>=MAX_WAIT)`.
- **When `sel_upd`:**
  - `bp_pc` = head pc, `bp_update` = 1.
  - `bp_update_taken` / `bp_update_target` = head fields.
  - `fetch_grant` = 0.
  - Head pops at the edge.
- **Otherwise:**
  - `bp_pc = fetch_pc`, `bp_update` = 0, `fetch_grant = fetch_req`.
  - `bp_update_taken` = 0, `bp_update_target` = 0.
- **wait_cnt:**
  - Cleared when `sel_upd` or `count==0`.
  - Otherwise incremented, saturating at MAX_WAIT.
- **Enqueue:** `free = DEPTH - count` is computed from the registered count. A pop in the same cycle does not create space.
  - `free ≥ 2`: both sources ready.
  - `free == 1`: if only one source is valid, that source is ready. If both are valid, only source `rr` is ready, and `rr` flips to the other source after that transfer.
  - `free == 0`: both ready = 0.
  - `res_ready` may depend on the other source's `res_valid`. Sources must not make `res_valid` depend on `res_ready`.
- **Order:** when both sources are accepted in the same cycle, source 0 is written ahead of source 1.
- **Bypass:** no enqueue-to-update bypass. An entry accepted at edge N is eligible for update no earlier than cycle N+1.
- **Count:** `count_next = count + accepted - popped`. Simultaneous push and pop is legal at every occupancy, including full (pop while full with no accept) and empty (push only).
- **Pointers:** wrap modulo DEPTH.
- **Flush:** none. Resolved updates are architectural facts and always drain.

## Timing

- **Reset (while `rst`=1 and the cycle after):**
  - State: count=0, pointers=0, wait_cnt=0, rr=0.
  - Outputs: `bp_update`=0, `bp_update_taken`=0, `bp_update_target`=0, `pending`=0.
  - Combinational outputs follow the empty state: `fetch_grant=fetch_req`, `bp_pc=fetch_pc`.
  - `res_ready` is forced to 0 while `rst`=1.
- **Reset mid-operation:** queued updates are discarded, no `bp_update` pulse is issued, and `res_ready` drops in the reset cycle.
- **Update latency:** accept at edge N → `bp_update` earliest in cycle N+1. The predictor table changes at edge N+2.
- **Forced-update bound:** with continuous `fetch_req` and `count < HIGH_WATER`, the head updates within MAX_WAIT+1 cycles of becoming non-empty.
- **Port sharing:** `fetch_grant` and `bp_update` are never both 1.

## Test plan

- **Reset:** assert `rst` for 2 cycles with `res_valid`=2'b11 → `res_ready`=0, `bp_update`=0, `pending`=0. Release with `fetch_req`=1 → `fetch_grant`=1, `bp_pc=fetch_pc`.
- **Idle drain:** `fetch_req`=0; source 0 pushes pc=0x100, taken=1, target=0x200 → next cycle `bp_update`=1, `bp_pc`=0x100, target=0x200; `pending` back to 0.
- **Starvation bound:** `fetch_req`=1 continuously; one update pushed (MAX_WAIT=8) → `fetch_grant`=1 for 8 cycles, then exactly one cycle with `bp_update`=1 and `fetch_grant`=0.
- **Dual push and high water:** both sources push each cycle with `fetch_req`=1 → order 0,1,0,1 in the FIFO. Once `pending`≥3, updates pre-empt fetch; `res_ready` honours `free`, with no overflow and no lost entry.
- **Full contention:** FIFO at DEPTH-1, both sources valid → only source `rr`=0 accepted, `rr` becomes 1. At the next single free slot with both valid, source 1 is accepted.
- **Reset mid-drain:** assert `rst` with `pending`=3 → no `bp_update` pulse, `pending`=0 after reset, later pushes start at index 0.

Source files
------------

// File: rtl/bp_update_sequencer_if.sv
// bp_update_sequencer_if: resolution sources, fetch lookup and predictor port bundle
interface bp_update_sequencer_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [1:0] res_valid;
  logic [1:0] res_ready;
  logic [1:0] res_taken;
  logic [31:0] res_pc0;
  logic [31:0] res_pc1;
  logic [31:0] res_target0;
  logic [31:0] res_target1;
  logic fetch_req;
  logic [31:0] fetch_pc;
  logic fetch_grant;
  logic [31:0] bp_pc;
  logic bp_update;
  logic bp_update_taken;
  logic [31:0] bp_update_target;
  logic [CW-1:0] pending;
  modport master (
    output res_valid, res_taken, res_pc0, res_pc1, res_target0, res_target1, fetch_req, fetch_pc,
    input res_ready, fetch_grant, bp_pc, bp_update, bp_update_taken, bp_update_target, pending
  );
  modport slave (
    input res_valid, res_taken, res_pc0, res_pc1, res_target0, res_target1, fetch_req, fetch_pc,
    output res_ready, fetch_grant, bp_pc, bp_update, bp_update_taken, bp_update_target, pending
  );
endinterface

// File: rtl/bp_update_sequencer.sv
// bp_update_sequencer: shares the predictor pc port between fetch lookups and queued training updates
module bp_update_sequencer #(
  parameter int DEPTH = 4,
  parameter int HIGH_WATER = 3,
  parameter int MAX_WAIT = 8
) (
  input logic clk,
  input logic rst,
  bp_update_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [31:0] pc_q [DEPTH];
  logic [31:0] pc_d [DEPTH];
  logic [31:0] tgt_q [DEPTH];
  logic [31:0] tgt_d [DEPTH];
  logic [DEPTH-1:0] tkn_q, tkn_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, wr1;
  logic [CW-1:0] count_q, count_d, free;
  logic [WW-1:0] wait_q, wait_d;
  logic rr_q, rr_d;
  logic sel_upd, contend;
  logic [1:0] ready, acc;
  always_comb begin
    free = CW'(DEPTH) - count_q;
    sel_upd = !rst && count_q != '0 &&
              (!bus.fetch_req || count_q >= CW'(HIGH_WATER) || wait_q >= WW'(MAX_WAIT));
    contend = free == CW'(1) && &bus.res_valid;
    // with one slot left and both sources valid, only the round-robin favourite gets it
    ready = (rst || free == '0) ? 2'b00 : contend ? (rr_q ? 2'b10 : 2'b01) : 2'b11;
    acc = bus.res_valid & ready;
    wr1 = tail_q + AW'(acc[0]);
    pc_d = pc_q;
    tgt_d = tgt_q;
    tkn_d = tkn_q;
    if (acc[0]) begin
      pc_d[tail_q] = bus.res_pc0;
      tgt_d[tail_q] = bus.res_target0;
      tkn_d[tail_q] = bus.res_taken[0];
    end
    if (acc[1]) begin
      pc_d[wr1] = bus.res_pc1;
      tgt_d[wr1] = bus.res_target1;
      tkn_d[wr1] = bus.res_taken[1];
    end
    head_d = head_q + AW'(sel_upd);
    tail_d = tail_q + AW'(acc[0]) + AW'(acc[1]);
    count_d = count_q + CW'(acc[0]) + CW'(acc[1]) - CW'(sel_upd);
    wait_d = (sel_upd || count_q == '0) ? '0 : wait_q >= WW'(MAX_WAIT) ? wait_q : wait_q + WW'(1);
    rr_d = (contend && acc != '0) ? ~rr_q : rr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      wait_q <= '0;
      rr_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      wait_q <= wait_d;
      rr_q <= rr_d;
    end
  end
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    tgt_q <= tgt_d;
    tkn_q <= tkn_d;
  end
  assign bus.res_ready = ready;
  assign bus.fetch_grant = !sel_upd && bus.fetch_req;
  assign bus.bp_pc = sel_upd ? pc_q[head_q] : bus.fetch_pc;
  assign bus.bp_update = sel_upd;
  assign bus.bp_update_taken = sel_upd && tkn_q[head_q];
  assign bus.bp_update_target = sel_upd ? tgt_q[head_q] : '0;
  assign bus.pending = rst ? '0 : count_q;
  a_port_shared: assert property (@(posedge clk) disable iff (rst) !(bus.fetch_grant && bus.bp_update));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));
endmodule

// File: tb/tb_bp_update_sequencer.sv
// tb_bp_update_sequencer: directed vectors with hand-computed expectations
module tb_bp_update_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  bp_update_sequencer_if #(.DEPTH(4)) bus ();
  bp_update_sequencer #(.DEPTH(4), .HIGH_WATER(3), .MAX_WAIT(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
    bus.res_valid = v;
    bus.res_pc0 = p0;
    bus.res_pc1 = p1;
    bus.res_target0 = p0 + 32'h10;
    bus.res_target1 = p1 + 32'h10;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.res_taken = 2'b00;
    bus.fetch_req = 1'b0;
    bus.fetch_pc = 32'h0;
    push(2'b11, 32'h0, 32'h0);
    rst = 1'b1;
    step();
    chk("rst_ready", bus.res_ready, 0);
    chk("rst_upd", bus.bp_update, 0);
    chk("rst_pend", bus.pending, 0);
    step();
    chk("rst_ready2", bus.res_ready, 0);
    chk("rst_tgt", bus.bp_update_target, 0);
    rst = 1'b0;
    push(2'b00, 32'h0, 32'h0);
    bus.fetch_req = 1'b1;
    bus.fetch_pc = 32'h1234;
    #1;
    chk("post_rst_grant", bus.fetch_grant, 1);
    chk("post_rst_pc", bus.bp_pc, 32'h1234);
    chk("post_rst_upd", bus.bp_update, 0);
    // idle drain
    bus.fetch_req = 1'b0;
    push(2'b01, 32'h100, 32'h0);
    bus.res_target0 = 32'h200;
    bus.res_taken = 2'b01;
    #1;
    chk("idle_ready", bus.res_ready[0], 1);
    step();
    push(2'b00, 32'h0, 32'h0);
    #1;
    chk("idle_upd", bus.bp_update, 1);
    chk("idle_pc", bus.bp_pc, 32'h100);
    chk("idle_taken", bus.bp_update_taken, 1);
    chk("idle_tgt", bus.bp_update_target, 32'h200);
    chk("idle_grant", bus.fetch_grant, 0);
    step();
    chk("idle_pend", bus.pending, 0);
    chk("idle_upd_off", bus.bp_update, 0);
    // starvation bound
    bus.fetch_req = 1'b1;
    bus.fetch_pc = 32'h3000;
    bus.res_taken = 2'b00;
    push(2'b10, 32'h0, 32'h140);
    step();
    push(2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("starve_grant%0d", i), bus.fetch_grant, 1);
      chk($sformatf("starve_upd%0d", i), bus.bp_update, 0);
      step();
    end
    chk("forced_upd", bus.bp_update, 1);
    chk("forced_grant", bus.fetch_grant, 0);
    chk("forced_pc", bus.bp_pc, 32'h140);
    chk("forced_tgt", bus.bp_update_target, 32'h150);
    chk("forced_taken", bus.bp_update_taken, 0);
    step();
    chk("forced_once", bus.bp_update, 0);
    chk("forced_regrant", bus.fetch_grant, 1);
    chk("forced_pend", bus.pending, 0);
    // dual push, high water and contention
    bus.res_taken = 2'b10;
    push(2'b11, 32'hA0, 32'hA1);
    #1;
    chk("dual_ready0", bus.res_ready, 2'b11);
    step();
    push(2'b11, 32'hA2, 32'hA3);
    #1;
    chk("dual_ready1", bus.res_ready, 2'b11);
    chk("dual_grant_lowcnt", bus.fetch_grant, 1);
    chk("dual_pend2", bus.pending, 2);
    step();
    push(2'b11, 32'hA4, 32'hA5);
    #1;
    chk("full_ready", bus.res_ready, 2'b00);
    chk("full_pend", bus.pending, 4);
    chk("hw_upd", bus.bp_update, 1);
    chk("hw_grant", bus.fetch_grant, 0);
    chk("ord_a0", bus.bp_pc, 32'hA0);
    chk("ord_a0_taken", bus.bp_update_taken, 0);
    step();
    #1;
    chk("rr0_ready", bus.res_ready, 2'b01);
    chk("ord_a1", bus.bp_pc, 32'hA1);
    chk("ord_a1_taken", bus.bp_update_taken, 1);
    chk("ord_a1_tgt", bus.bp_update_target, 32'hB1);
    step();
    bus.res_pc0 = 32'hA6;
    #1;
    chk("rr1_ready", bus.res_ready, 2'b10);
    chk("rr1_pend", bus.pending, 3);
    chk("ord_a2", bus.bp_pc, 32'hA2);
    step();
    push(2'b00, 32'h0, 32'h0);
    #1;
    chk("ord_a3", bus.bp_pc, 32'hA3);
    step();
    bus.fetch_req = 1'b0;
    #1;
    chk("ord_a4", bus.bp_pc, 32'hA4);
    chk("ord_a4_upd", bus.bp_update, 1);
    step();
    chk("ord_a5", bus.bp_pc, 32'hA5);
    chk("ord_a5_taken", bus.bp_update_taken, 1);
    step();
    chk("drain_pend", bus.pending, 0);
    chk("drain_upd", bus.bp_update, 0);
    // reset mid-drain
    bus.fetch_req = 1'b1;
    push(2'b11, 32'hC0, 32'hC1);
    step();
    push(2'b01, 32'hC2, 32'h0);
    step();
    push(2'b00, 32'h0, 32'h0);
    #1;
    chk("mid_pend3", bus.pending, 3);
    rst = 1'b1;
    push(2'b11, 32'hE0, 32'hE1);
    #1;
    chk("mid_rst_upd", bus.bp_update, 0);
    chk("mid_rst_ready", bus.res_ready, 0);
    chk("mid_rst_pend", bus.pending, 0);
    chk("mid_rst_grant", bus.fetch_grant, 1);
    step();
    rst = 1'b0;
    push(2'b00, 32'h0, 32'h0);
    bus.fetch_req = 1'b0;
    #1;
    chk("after_rst_pend", bus.pending, 0);
    chk("after_rst_upd", bus.bp_update, 0);
    push(2'b10, 32'h0, 32'hD1);
    step();
    push(2'b00, 32'h0, 32'h0);
    #1;
    chk("after_rst_pc", bus.bp_pc, 32'hD1);
    chk("after_rst_push_upd", bus.bp_update, 1);
    chk("after_rst_tgt", bus.bp_update_target, 32'hE1);
    step();
    chk("after_rst_drained", bus.pending, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
